// File: rtl/spi_cmd_ctrl.sv
// SPI command decoder: turns {rw,addr} + data bytes from an SPI slave into register bus requests.
// Optional macro SPI_CMD_ADDR_INC_EN enables address auto-increment after each completed access.
module spi_cmd_ctrl #(
  parameter int ADDR_W  = 7,
  parameter int TMO_CYC = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cs,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_req,
  output logic              reg_wr,
  input  logic [7:0]        reg_rdata,
  input  logic              reg_ack,
  output logic              err
);

  localparam int CW = $clog2(TMO_CYC + 1);

  typedef enum logic [2:0] {IDLE, CMD, WDAT, WREQ, RREQ, RDAT} state_t;

  state_t            state, nstate;
  logic              cs_s1, cs_s2, cs_q;
  logic [1:0]        fill;
  logic              armed, eof;
  logic              fstart, frise;
  logic [CW-1:0]     tmo_cnt, n_cnt;
  logic              tmo_hit;
  logic [ADDR_W-1:0] addr_nxt, n_addr;
  logic [7:0]        n_tx, n_wdata;
  logic              n_req, n_wr, n_err, n_eof;

  // armed only rises once a real synced high has been seen, so a cs held low
  // across reset release is not mistaken for a frame start
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cs_s1 <= 1'b1;
      cs_s2 <= 1'b1;
      cs_q  <= 1'b1;
      fill  <= 2'b00;
      armed <= 1'b0;
    end else begin
      cs_s1 <= cs;
      cs_s2 <= cs_s1;
      cs_q  <= cs_s2;
      fill  <= {fill[0], 1'b1};
      armed <= armed | (fill[1] & cs_s2);
    end
  end

  assign fstart  = armed & cs_q & ~cs_s2;
  assign frise   = ~cs_q & cs_s2;
  assign tmo_hit = (tmo_cnt == CW'(TMO_CYC - 1));

`ifdef SPI_CMD_ADDR_INC_EN
  assign addr_nxt = reg_addr + 1'b1;
`else
  assign addr_nxt = reg_addr;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      tx_data   <= 8'h00;
      reg_addr  <= '0;
      reg_wdata <= 8'h00;
      reg_req   <= 1'b0;
      reg_wr    <= 1'b0;
      err       <= 1'b0;
      tmo_cnt   <= '0;
      eof       <= 1'b0;
    end else begin
      state     <= nstate;
      tx_data   <= n_tx;
      reg_addr  <= n_addr;
      reg_wdata <= n_wdata;
      reg_req   <= n_req;
      reg_wr    <= n_wr;
      err       <= n_err;
      tmo_cnt   <= n_cnt;
      eof       <= n_eof;
    end
  end

  always_comb begin
    nstate  = state;
    n_tx    = tx_data;
    n_addr  = reg_addr;
    n_wdata = reg_wdata;
    n_req   = reg_req;
    n_wr    = reg_wr;
    n_err   = err;
    n_cnt   = tmo_cnt;
    n_eof   = eof | frise;
    case (state)
      IDLE: if (fstart) begin
        nstate = CMD;
        n_err  = 1'b0;
        n_tx   = 8'h00;
        n_eof  = 1'b0;
      end
      CMD: begin
        if (n_eof) nstate = IDLE;
        else if (rx_valid) begin
          n_addr = rx_data[ADDR_W-1:0];
          if (rx_data[7]) begin
            nstate = RREQ;
            n_wr   = 1'b0;
            n_req  = 1'b1;
            n_cnt  = '0;
          end else begin
            nstate = WDAT;
          end
        end
      end
      WDAT: begin
        if (n_eof) nstate = IDLE;
        else if (rx_valid) begin
          nstate  = WREQ;
          n_wdata = rx_data;
          n_wr    = 1'b1;
          n_req   = 1'b1;
          n_cnt   = '0;
        end
      end
      RDAT: begin
        if (n_eof) nstate = IDLE;
        else if (rx_valid) begin
          nstate = RREQ;
          n_addr = addr_nxt;
          n_req  = 1'b1;
          n_cnt  = '0;
        end
      end
      WREQ, RREQ: begin
        // a byte arriving while the bus is busy is an overrun and is dropped
        if (rx_valid) n_err = 1'b1;
        if (reg_ack || tmo_hit) begin
          n_req = 1'b0;
          n_cnt = '0;
          if (!reg_ack) n_err = 1'b1;
          if (state == RREQ) begin
            n_tx   = reg_ack ? reg_rdata : 8'hFF;
            nstate = n_eof ? IDLE : RDAT;
          end else begin
            n_addr = addr_nxt;
            nstate = n_eof ? IDLE : WDAT;
          end
        end else begin
          n_cnt = tmo_cnt + 1'b1;
        end
      end
      default: nstate = IDLE;
    endcase
  end

endmodule

// File: doc/spi_cmd_ctrl.md
SPI_CMD_CTRL -- requirements
Module: spi_cmd_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, register address width; must equal 7 so that {rw, addr} fits one byte.
REQ-002 SHALL have parameter TMO_CYC, default 255, maximum clk cycles to wait for reg_ack before abandoning a request.
REQ-003 SHALL have port clk, input, 1, system clock.
REQ-004 SHALL have port rstn, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port cs, input, 1, SPI chip select, active-low, asynchronous to clk.
REQ-006 SHALL have port rx_data, input, 8, byte received from the SPI slave, valid with rx_valid.
REQ-007 SHALL have port rx_valid, input, 1, one-clk pulse, one received byte.
REQ-008 SHALL have port tx_data, output, 8, byte the SPI slave shifts out on the next byte slot.
REQ-009 SHALL have port reg_addr, output, ADDR_W, register bus address.
REQ-010 SHALL have port reg_wdata, output, 8, register bus write data.
REQ-011 SHALL have port reg_req, output, 1, register bus request, held until reg_ack or timeout.
REQ-012 SHALL have port reg_wr, output, 1, 1 = write, 0 = read; valid while reg_req is high.
REQ-013 SHALL have port reg_rdata, input, 8, read data, valid with reg_ack.
REQ-014 SHALL have port reg_ack, input, 1, one-clk completion pulse.
REQ-015 SHALL have port err, output, 1, sticky frame error flag.

Function
REQ-016 SHALL synchronise cs through two flops (reset value 1); frame start = synced cs falling, frame end = synced cs rising.
REQ-017 SHALL implement states IDLE, CMD, WDAT, WREQ, RREQ, RDAT.
REQ-018 SHALL on frame start go IDLE->CMD, clear err and set tx_data to 8'h00.
REQ-019 SHALL in CMD, on rx_valid, latch addr = rx_data[6:0]; rx_data[7]=1 -> RREQ with reg_wr=0; rx_data[7]=0 -> WDAT.
REQ-020 SHALL in WDAT, on rx_valid, drive reg_wdata = rx_data, reg_wr=1, reg_req=1, and go to WREQ.
REQ-021 SHALL in WREQ/RREQ hold reg_req, reg_addr, reg_wr and reg_wdata stable until reg_ack, then drop reg_req on the following cycle.
REQ-022 SHALL on reg_ack in RREQ register tx_data = reg_rdata and go to RDAT.
REQ-023 SHALL on reg_ack in WREQ go to WDAT.
REQ-024 SHALL in RDAT, on rx_valid (dummy byte complete), advance the address per REQ-033 and go to RREQ.
REQ-025 SHALL count cycles in WREQ/RREQ; on reaching TMO_CYC without reg_ack, drop reg_req, set err, load tx_data 8'hFF on a read, and continue as if acked.
REQ-026 SHALL treat rx_valid arriving in WREQ/RREQ as overrun: drop the byte, set err, stay in state.
REQ-027 SHALL on frame end in CMD/WDAT/RDAT go to IDLE next cycle; in WREQ/RREQ first complete the outstanding request (ack or timeout), then go to IDLE.
REQ-028 SHALL ignore rx_valid in IDLE.
REQ-029 SHALL require the read round trip (rx_valid to reg_ack) to finish before the master's next sck edge; the SPI master guarantees an inter-byte gap of at least TMO_CYC+4 clk.

Reset
REQ-030 SHALL, while rstn=0, force state=IDLE, tx_data=8'h00, reg_addr=0, reg_wdata=0, reg_req=0, reg_wr=0, err=0 and the timeout counter to 0.
REQ-031 SHALL, on reset mid-request, drop reg_req immediately; the register bus discards that request.
REQ-032 SHALL, on reset release with cs already low, wait for a new cs falling edge before accepting bytes.

Configuration
REQ-033 SHALL, with macro SPI_CMD_ADDR_INC_EN defined, increment the address (mod 2^ADDR_W, 7'h7F wraps to 7'h00) after every completed write or read; without it the address stays fixed for the whole frame.

Verification
REQ-034 SHALL cover: frame 8'h05,8'h3C,8'h4D (INC_EN) -> writes 0x3C@0x05, 0x4D@0x06; err=0.
REQ-035 SHALL cover: frame 8'h90 + 2 dummies, reg bank 0x10=0xAA, 0x11=0xBB (INC_EN) -> tx_data 0xAA then 0xBB; reads at 0x10, 0x11, 0x12.
REQ-036 SHALL cover: write burst starting at 7'h7F, 2 data bytes -> INC_EN writes 0x7F then 0x00; without the macro both at 0x7F.
REQ-037 SHALL cover: read with reg_ack withheld -> reg_req drops after TMO_CYC cycles, tx_data=0xFF, err=1, err clears at next cs falling.
REQ-038 SHALL cover: rx_valid injected during WREQ -> byte dropped, err=1, pending write completes unchanged.
REQ-039 SHALL cover: cs raised during RREQ -> reg_ack still accepted, then IDLE; rstn pulsed mid-WREQ -> reg_req=0 at once, all outputs at reset values.
